// File: rtl/ethernet_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : ethernet_tx_if
// Purpose  : Frame request, payload byte stream and line outputs of ethernet_tx.
// Revision : 1.0
// ============================================================================
interface ethernet_tx_if;
    logic        i_start;
    logic [47:0] i_dst_mac;
    logic [47:0] i_src_mac;
    logic [15:0] i_ethertype;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_last;
    logic        o_ready;
    logic        o_busy;
    logic        o_tx_en;
    logic        o_ethernet;
    logic        o_done;
    logic        o_err;

    modport master (
        output i_start, i_dst_mac, i_src_mac, i_ethertype, i_data, i_valid, i_last,
        input  o_ready, o_busy, o_tx_en, o_ethernet, o_done, o_err
    );

    modport slave (
        input  i_start, i_dst_mac, i_src_mac, i_ethertype, i_data, i_valid, i_last,
        output o_ready, o_busy, o_tx_en, o_ethernet, o_done, o_err
    );
endinterface
`default_nettype wire

// File: rtl/ethernet_tx.sv
`default_nettype none
// ============================================================================
// Module   : ethernet_tx
// Purpose  : 10BASE-T style Manchester frame transmitter, one clock per half-bit.
//            Define ETHERNET_TX_FCS_EN to append a CRC-32 frame check sequence.
// Revision : 1.0
// ============================================================================
module ethernet_tx #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_PAYLOAD    = 46,
    parameter int MAX_PAYLOAD    = 1500,
    parameter int IFG_BITS       = 96
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ethernet_tx_if.slave bus
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PRE   = 4'd1;
    localparam logic [3:0] S_SFD   = 4'd2;
    localparam logic [3:0] S_DST   = 4'd3;
    localparam logic [3:0] S_SRC   = 4'd4;
    localparam logic [3:0] S_TYPE  = 4'd5;
    localparam logic [3:0] S_PAY   = 4'd6;
    localparam logic [3:0] S_PAD   = 4'd7;
    localparam logic [3:0] S_FCS   = 4'd8;
    localparam logic [3:0] S_TPIDL = 4'd9;
    localparam logic [3:0] S_IFG   = 4'd10;
`ifdef ETHERNET_TX_FCS_EN
    localparam logic [3:0] S_AFTER = S_FCS;
    localparam logic [31:0] C_POLY = 32'hEDB88320;
`else
    localparam logic [3:0] S_AFTER = S_TPIDL;
`endif
    localparam logic [15:0] C_PRE_LAST = 16'(PREAMBLE_BYTES - 1);
    localparam logic [15:0] C_MIN      = 16'(MIN_PAYLOAD);
    localparam logic [15:0] C_MAX      = 16'(MAX_PAYLOAD);
    localparam logic [15:0] C_IFG_LAST = 16'(2 * IFG_BITS - 1);

    logic [3:0]  state_q, state_d;
    logic        phase_q, phase_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] type_q, type_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        hold_last_q, hold_last_d;
    logic        cur_last_q, cur_last_d;
    logic        last_acc_q, last_acc_d;
    logic [15:0] acc_cnt_q, acc_cnt_d;
`ifdef ETHERNET_TX_FCS_EN
    logic [31:0] crc_q, crc_d;
`endif
    logic        eth_q, eth_d;
    logic        tx_en_q, tx_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        w_accept;
    logic        w_ready;
    logic        w_take;
    logic        w_shifting;
    logic        w_boundary;
    logic        w_underrun;
    logic        w_overrun;
    logic        w_bit_d;

    assign w_accept   = bus.i_start & ~busy_q;
    assign w_ready    = ((state_q == S_TYPE) | (state_q == S_PAY)) & ~hold_vld_q & ~last_acc_q;
    assign w_take     = bus.i_valid & w_ready;
    assign w_shifting = (state_q >= S_PRE) & (state_q <= S_FCS);
    assign w_boundary = w_shifting & phase_q & (bit_q == 3'd7);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            bit_q       <= 3'd0;
            cnt_q       <= 16'd0;
            byte_q      <= 8'd0;
            dst_q       <= 48'd0;
            src_q       <= 48'd0;
            type_q      <= 16'd0;
            hold_q      <= 8'd0;
            hold_vld_q  <= 1'b0;
            hold_last_q <= 1'b0;
            cur_last_q  <= 1'b0;
            last_acc_q  <= 1'b0;
            acc_cnt_q   <= 16'd0;
`ifdef ETHERNET_TX_FCS_EN
            crc_q       <= 32'hFFFF_FFFF;
`endif
            eth_q       <= 1'b0;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            type_q      <= type_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            hold_last_q <= hold_last_d;
            cur_last_q  <= cur_last_d;
            last_acc_q  <= last_acc_d;
            acc_cnt_q   <= acc_cnt_d;
`ifdef ETHERNET_TX_FCS_EN
            crc_q       <= crc_d;
`endif
            eth_q       <= eth_d;
            tx_en_q     <= tx_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // The _q registers describe the half-bit currently on the line.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        dst_d       = dst_q;
        src_d       = src_q;
        type_d      = type_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        hold_last_d = hold_last_q;
        cur_last_d  = cur_last_q;
        last_acc_d  = last_acc_q;
        acc_cnt_d   = acc_cnt_q;
`ifdef ETHERNET_TX_FCS_EN
        crc_d       = crc_q;
`endif
        w_underrun  = 1'b0;
        w_overrun   = 1'b0;

        if (w_take) begin
            hold_d     = bus.i_data;
            hold_vld_d = 1'b1;
            acc_cnt_d  = acc_cnt_q + 16'd1;
            if (bus.i_last) begin
                last_acc_d  = 1'b1;
                hold_last_d = 1'b1;
            end else if (acc_cnt_q + 16'd1 == C_MAX) begin
                last_acc_d  = 1'b1;
                hold_last_d = 1'b1;
                w_overrun   = 1'b1;
            end else begin
                hold_last_d = 1'b0;
            end
        end

        if (w_shifting) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                bit_d = bit_q + 3'd1;
`ifdef ETHERNET_TX_FCS_EN
                if (state_q == S_FCS) begin
                    crc_d = {1'b0, crc_q[31:1]};
                end else if (state_q >= S_DST && state_q <= S_PAD) begin
                    crc_d = {1'b0, crc_q[31:1]} ^ ((crc_q[0] ^ byte_q[bit_q]) ? C_POLY : 32'h0);
                end
`endif
            end
        end

        if (w_boundary) begin
            case (state_q)
                S_PRE: begin
                    if (cnt_q == C_PRE_LAST) begin
                        state_d = S_SFD;
                        byte_d  = 8'hD5;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d  = cnt_q + 16'd1;
                        byte_d = 8'h55;
                    end
                end
                S_SFD: begin
                    state_d = S_DST;
                    byte_d  = dst_q[47:40];
                    cnt_d   = 16'd0;
                end
                S_DST: begin
                    if (cnt_q == 16'd5) begin
                        state_d = S_SRC;
                        byte_d  = src_q[47:40];
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d  = cnt_q + 16'd1;
                        byte_d = dst_q[39:32];
                        dst_d  = {dst_q[39:0], 8'h00};
                    end
                end
                S_SRC: begin
                    if (cnt_q == 16'd5) begin
                        state_d = S_TYPE;
                        byte_d  = type_q[15:8];
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d  = cnt_q + 16'd1;
                        byte_d = src_q[39:32];
                        src_d  = {src_q[39:0], 8'h00};
                    end
                end
                S_TYPE: begin
                    if (cnt_q == 16'd0) begin
                        cnt_d  = 16'd1;
                        byte_d = type_q[7:0];
                    end else if (hold_vld_q) begin
                        state_d    = S_PAY;
                        byte_d     = hold_q;
                        hold_vld_d = 1'b0;
                        cur_last_d = hold_last_q;
                        cnt_d      = 16'd1;
                    end else begin
                        state_d    = S_TPIDL;
                        cnt_d      = 16'd0;
                        w_underrun = 1'b1;
                    end
                end
                S_PAY: begin
                    if (cur_last_q) begin
                        if (cnt_q < C_MIN) begin
                            state_d = S_PAD;
                            byte_d  = 8'h00;
                            cnt_d   = cnt_q + 16'd1;
                        end else begin
                            state_d = S_AFTER;
                            cnt_d   = 16'd0;
                        end
                    end else if (hold_vld_q) begin
                        byte_d     = hold_q;
                        hold_vld_d = 1'b0;
                        cur_last_d = hold_last_q;
                        cnt_d      = cnt_q + 16'd1;
                    end else begin
                        // Underrun truncates the frame: no pad and no FCS.
                        state_d    = S_TPIDL;
                        cnt_d      = 16'd0;
                        w_underrun = 1'b1;
                    end
                end
                S_PAD: begin
                    if (cnt_q == C_MIN) begin
                        state_d = S_AFTER;
                        cnt_d   = 16'd0;
                    end else begin
                        byte_d = 8'h00;
                        cnt_d  = cnt_q + 16'd1;
                    end
                end
`ifdef ETHERNET_TX_FCS_EN
                S_FCS: begin
                    if (cnt_q == 16'd3) begin
                        state_d = S_TPIDL;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
`endif
                default: ;
            endcase
        end

        if (state_q == S_TPIDL) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'd3) begin
                state_d = S_IFG;
                cnt_d   = 16'd0;
            end
        end else if (state_q == S_IFG) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == C_IFG_LAST) begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        end

        if (w_accept) begin
            state_d     = S_PRE;
            phase_d     = 1'b0;
            bit_d       = 3'd0;
            cnt_d       = 16'd0;
            byte_d      = 8'h55;
            dst_d       = bus.i_dst_mac;
            src_d       = bus.i_src_mac;
            type_d      = bus.i_ethertype;
            hold_vld_d  = 1'b0;
            hold_last_d = 1'b0;
            cur_last_d  = 1'b0;
            last_acc_d  = 1'b0;
            acc_cnt_d   = 16'd0;
`ifdef ETHERNET_TX_FCS_EN
            crc_d       = 32'hFFFF_FFFF;
`endif
        end
    end

    // Line outputs are registered from next-state values so they align with it.
    always_comb begin
        w_bit_d = byte_d[bit_d];
`ifdef ETHERNET_TX_FCS_EN
        if (state_d == S_FCS) begin
            w_bit_d = ~crc_d[0];
        end
`endif
        tx_en_d = (state_d >= S_PRE) && (state_d <= S_FCS);
        eth_d   = tx_en_d ? (phase_d ? w_bit_d : ~w_bit_d) : (state_d == S_TPIDL);
        done_d  = (state_d == S_IFG) && (cnt_d == C_IFG_LAST);
        busy_d  = (state_d != S_IDLE) && !done_d;
        err_d   = w_underrun | w_overrun;
    end

    assign bus.o_ready    = w_ready;
    assign bus.o_busy     = busy_q;
    assign bus.o_tx_en    = tx_en_q;
    assign bus.o_ethernet = eth_q;
    assign bus.o_done     = done_q;
    assign bus.o_err      = err_q;

endmodule
`default_nettype wire
